mem_arbiter: RTL and testbench

- Shares the single unified main memory between I-cache miss fills, D-cache miss fills and D-side write-through stores.
- Sequences each cache-block fill as a burst of pipelined word reads, counts the returned words, and drives the cache data-array and tag write strobes.
- Sits between the fetch/memory pipeline stages and the multi-cycle memory.
- The pipeline stall logic uses ifill_busy, dfill_busy and wr_ack.

---
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares one unified, pipelined main memory between I-cache miss fills,
// D-cache miss fills and D-side write-through stores. A cache-block fill is
// issued as BLK_WORDS back-to-back word reads. The returned words are counted
// and steered into the owning cache's data array. The tag/valid write pulses
// when the last word arrives.
//
// Request semantics: icache_miss, dcache_miss and dmem_wr are level requests.
// A requester keeps its request high until it is serviced. For a store, that
// is the cycle in which wr_ack is high, and the write is on the memory bus in
// that same cycle. For a miss, that is the cycle in which its tag_we pulses.
// Memory read data is accepted in any cycle that has mem_data_valid high
// during FILL. mem_data_valid is ignored in IDLE.
//
// Ports
//   clk, rst                        clock (rising edge), async active-high reset
//   icache_miss/icache_addr         I-side miss request and byte address
//   dcache_miss/dcache_addr         D-side miss request and byte address
//   dmem_wr/dmem_wr_addr/_data      write-through store request
//   wr_ack                          store issued this cycle
//   mem_enable/mem_wr/mem_addr/
//   mem_data_out                    memory command bus
//   mem_data_valid/mem_data_in      memory read return
//   fill_data/fill_word             word and word index for the data array
//   icache_fill_we/dcache_fill_we   data-array write enables
//   icache_tag_we/dcache_tag_we     tag/valid write pulses
//   ifill_busy/dfill_busy           fill in progress, per owner
//   dbg_state                       FSM state (0 = IDLE, 1 = FILL)
module mem_arbiter #(
  parameter int BLK_WORDS = 8,
  parameter int IDX_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             icache_miss,
  input  logic [15:0]      icache_addr,
  input  logic             dcache_miss,
  input  logic [15:0]      dcache_addr,
  input  logic             dmem_wr,
  input  logic [15:0]      dmem_wr_addr,
  input  logic [15:0]      dmem_wr_data,
  output logic             wr_ack,
  output logic             mem_enable,
  output logic             mem_wr,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_data_out,
  input  logic             mem_data_valid,
  input  logic [15:0]      mem_data_in,
  output logic [15:0]      fill_data,
  output logic [IDX_W-1:0] fill_word,
  output logic             icache_fill_we,
  output logic             dcache_fill_we,
  output logic             icache_tag_we,
  output logic             dcache_tag_we,
  output logic             ifill_busy,
  output logic             dfill_busy,
  output logic             dbg_state
);

  // Block base: the byte-address bits above the word index and byte offset.
  localparam int BASE_W = 15 - IDX_W;
  localparam logic [IDX_W:0]   BLK_N  = (IDX_W+1)'(BLK_WORDS);
  localparam logic [IDX_W-1:0] LAST_W = IDX_W'(BLK_WORDS - 1);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;            // 0 = I, 1 = D
  logic              last_owner_q, last_owner_d;
  logic [BASE_W-1:0] blk_base_q, blk_base_d;
  logic [IDX_W:0]    iss_cnt_q, iss_cnt_d;        // 0..BLK_WORDS
  logic [IDX_W-1:0]  rcv_cnt_q, rcv_cnt_d;
  logic              grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;  // I wins the first tie
      blk_base_q   <= '0;
      iss_cnt_q    <= '0;
      rcv_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      blk_base_q   <= blk_base_d;
      iss_cnt_q    <= iss_cnt_d;
      rcv_cnt_q    <= rcv_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_owner_d   = last_owner_q;
    blk_base_d     = blk_base_q;
    iss_cnt_d      = iss_cnt_q;
    rcv_cnt_d      = rcv_cnt_q;
    grant          = 1'b0;
    wr_ack         = 1'b0;
    mem_enable     = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_data_out   = '0;
    fill_data      = '0;
    icache_fill_we = 1'b0;
    dcache_fill_we = 1'b0;
    icache_tag_we  = 1'b0;
    dcache_tag_we  = 1'b0;
    ifill_busy     = 1'b0;
    dfill_busy     = 1'b0;

    case (state_q)
      IDLE: begin
        if (dmem_wr) begin
          // Stores go straight through and pre-empt miss acceptance.
          wr_ack       = 1'b1;
          mem_enable   = 1'b1;
          mem_wr       = 1'b1;
          mem_addr     = dmem_wr_addr;
          mem_data_out = dmem_wr_data;
        end else if (icache_miss || dcache_miss) begin
          // A lone miss wins outright. On a tie, the side that did not own
          // the previous fill wins.
          grant      = (icache_miss && dcache_miss) ? ~last_owner_q : dcache_miss;
          owner_d    = grant;
          blk_base_d = grant ? dcache_addr[15:IDX_W+1] : icache_addr[15:IDX_W+1];
          iss_cnt_d  = '0;
          rcv_cnt_d  = '0;
          state_d    = FILL;
        end
      end

      FILL: begin
        ifill_busy = ~owner_q;
        dfill_busy = owner_q;
        if (iss_cnt_q < BLK_N) begin
          mem_enable = 1'b1;
          mem_addr   = {blk_base_q, iss_cnt_q[IDX_W-1:0], 1'b0};
          iss_cnt_d  = iss_cnt_q + 1'b1;
        end
        // The memory returns reads in order, so the receive count is the word index.
        if (mem_data_valid) begin
          fill_data      = mem_data_in;
          icache_fill_we = ~owner_q;
          dcache_fill_we = owner_q;
          rcv_cnt_d      = rcv_cnt_q + 1'b1;
          if (rcv_cnt_q == LAST_W) begin
            icache_tag_we = ~owner_q;
            dcache_tag_we = owner_q;
            last_owner_d  = owner_q;
            state_d       = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign fill_word = rcv_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a table of single-cycle vectors (stores, stray
// read data, one cycle-exact I fill), followed by hand-written sequences for
// arbitration, round-robin, a store held off by a fill, and reset mid-fill.
// A pipelined memory model with a fixed latency of 4 cycles returns
// mem_data(addr). Read addresses, stores and fill words are checked against
// expected queues.
module tb_mem_arbiter;
  localparam int BW  = 8;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_miss, dcache_miss, dmem_wr;
  logic [15:0] icache_addr, dcache_addr, dmem_wr_addr, dmem_wr_data;
  logic        wr_ack, mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_data_out;
  logic        mem_data_valid;
  logic [15:0] mem_data_in, fill_data;
  logic [2:0]  fill_word;
  logic        icache_fill_we, dcache_fill_we, icache_tag_we, dcache_tag_we;
  logic        ifill_busy, dfill_busy, dbg_state;

  mem_arbiter #(.BLK_WORDS(BW), .IDX_W(3)) dut (
    .clk(clk), .rst(rst),
    .icache_miss(icache_miss), .icache_addr(icache_addr),
    .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
    .dmem_wr(dmem_wr), .dmem_wr_addr(dmem_wr_addr), .dmem_wr_data(dmem_wr_data),
    .wr_ack(wr_ack), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_data_valid(mem_data_valid), .mem_data_in(mem_data_in),
    .fill_data(fill_data), .fill_word(fill_word),
    .icache_fill_we(icache_fill_we), .dcache_fill_we(dcache_fill_we),
    .icache_tag_we(icache_tag_we), .dcache_tag_we(dcache_tag_we),
    .ifill_busy(ifill_busy), .dfill_busy(dfill_busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fill_cnt = 0;

  logic [20:0] exp_q[$];   // {owner, last, word, data}
  logic [15:0] rd_q[$];    // expected read addresses
  logic [31:0] wr_q[$];    // expected stores {addr, data}
  int          ret_due[$]; // memory model return schedule
  logic [15:0] ret_dat[$];

  typedef struct packed {
    logic        imiss; logic [15:0] iaddr;
    logic        dmiss; logic [15:0] daddr;
    logic        wr;    logic [15:0] waddr; logic [15:0] wdata;
    logic        mv;    logic [1:0]  sb;    // force valid; push I(1)/D(2) block
    logic        e_en;  logic e_wr; logic [15:0] e_addr; logic [15:0] e_dout;
    logic        e_ack; logic e_ifwe; logic e_dfwe; logic e_itag; logic e_dtag;
    logic        e_ibusy; logic e_dbusy;
  } vec_t;
  vec_t vt[$];

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C96;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 16'(act), 16'(exp));
  endtask

  task automatic fail_now(input string name, input logic [15:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %h expected nothing (cycle %0d)", name, act, cyc);
  endtask

  task automatic push_block(input logic owner, input logic [15:0] addr);
    for (int w = 0; w < BW; w++) begin
      logic [2:0]  wi;
      logic [15:0] a;
      wi = 3'(w);
      a  = {addr[15:4], wi, 1'b0};
      rd_q.push_back(a);
      exp_q.push_back({owner, (w == BW-1), wi, mdata(a)});
    end
  endtask

  // ---------------- memory model driver ----------------
  task automatic mem_drive();
    if (ret_due.size() > 0 && ret_due[0] == cyc) begin
      mem_data_valid = 1'b1;
      mem_data_in    = ret_dat.pop_front();
      void'(ret_due.pop_front());
    end else begin
      mem_data_valid = 1'b0;
      mem_data_in    = 16'($urandom);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    mem_drive();
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [20:0] mon_e;
  logic [31:0] mon_w;
  always @(negedge clk) begin
    if (!rst) begin
      chk1("wr_ack_vs_write", wr_ack, mem_enable && mem_wr);
      if (mem_enable && !mem_wr) begin
        ret_due.push_back(cyc + LAT);
        ret_dat.push_back(mdata(mem_addr));
        if (rd_q.size() == 0) fail_now("rd_unexpected", mem_addr);
        else chk("rd_addr", mem_addr, rd_q.pop_front());
      end
      if (mem_enable && mem_wr) begin
        if (wr_q.size() == 0) fail_now("wr_unexpected", mem_addr);
        else begin
          mon_w = wr_q.pop_front();
          chk("wr_addr", mem_addr, mon_w[31:16]);
          chk("wr_data", mem_data_out, mon_w[15:0]);
        end
      end
      if (icache_fill_we || dcache_fill_we) begin
        fill_cnt++;
        if (exp_q.size() == 0) fail_now("fill_unexpected", fill_data);
        else begin
          mon_e = exp_q.pop_front();
          chk1("fill_owner", dcache_fill_we, mon_e[20]);
          chk1("fill_both_we", icache_fill_we && dcache_fill_we, 1'b0);
          chk("fill_word", 16'(fill_word), 16'(mon_e[18:16]));
          chk("fill_data", fill_data, mon_e[15:0]);
          chk1("tag_we", mon_e[20] ? dcache_tag_we : icache_tag_we, mon_e[19]);
          chk1("tag_other", mon_e[20] ? icache_tag_we : dcache_tag_we, 1'b0);
        end
      end else if (icache_tag_we || dcache_tag_we) begin
        fail_now("tag_without_fill", 16'({icache_tag_we, dcache_tag_we}));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk_zero(input string tag);
    chk1({tag, "_wr_ack"}, wr_ack, 1'b0);
    chk1({tag, "_mem_enable"}, mem_enable, 1'b0);
    chk1({tag, "_mem_wr"}, mem_wr, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 16'h0000);
    chk({tag, "_mem_data_out"}, mem_data_out, 16'h0000);
    chk({tag, "_fill_data"}, fill_data, 16'h0000);
    chk({tag, "_fill_word"}, 16'(fill_word), 16'h0000);
    chk1({tag, "_fill_we"}, icache_fill_we || dcache_fill_we, 1'b0);
    chk1({tag, "_tag_we"}, icache_tag_we || dcache_tag_we, 1'b0);
    chk1({tag, "_busy"}, ifill_busy || dfill_busy, 1'b0);
  endtask

  task automatic flush();
    exp_q.delete(); rd_q.delete(); wr_q.delete();
    ret_due.delete(); ret_dat.delete();
    mem_data_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    icache_miss = 1'b0; dcache_miss = 1'b0; dmem_wr = 1'b0;
    flush();
    step();
    @(negedge clk);
    chk_zero("reset");
    step();
    rst = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    icache_miss = v.imiss; icache_addr = v.iaddr;
    dcache_miss = v.dmiss; dcache_addr = v.daddr;
    dmem_wr = v.wr; dmem_wr_addr = v.waddr; dmem_wr_data = v.wdata;
    if (v.mv) begin
      mem_data_valid = 1'b1;
      mem_data_in    = 16'hDEAD;
    end
    if (v.wr) wr_q.push_back({v.waddr, v.wdata});
    if (v.sb == 2'd1) push_block(1'b0, v.iaddr);
    if (v.sb == 2'd2) push_block(1'b1, v.daddr);
    @(negedge clk);
    chk1("v_mem_enable", mem_enable, v.e_en);
    chk1("v_wr_ack", wr_ack, v.e_ack);
    chk1("v_icache_fill_we", icache_fill_we, v.e_ifwe);
    chk1("v_dcache_fill_we", dcache_fill_we, v.e_dfwe);
    chk1("v_icache_tag_we", icache_tag_we, v.e_itag);
    chk1("v_dcache_tag_we", dcache_tag_we, v.e_dtag);
    chk1("v_ifill_busy", ifill_busy, v.e_ibusy);
    chk1("v_dfill_busy", dfill_busy, v.e_dbusy);
    if (v.e_en) begin
      chk1("v_mem_wr", mem_wr, v.e_wr);
      chk("v_mem_addr", mem_addr, v.e_addr);
      if (v.e_wr) chk("v_mem_data_out", mem_data_out, v.e_dout);
    end
    step();
  endtask

  // Runs from the accept cycle (index 0) of a fill by `own` until its tag_we.
  // The owner's miss is dropped in the cycle after the tag_we.
  // An optional store is raised at index store_at.
  task automatic wait_tag(input logic own, input int store_at,
                          input logic [15:0] saddr, input logic [15:0] sdata,
                          output int n);
    logic tag;
    n = -1;
    for (int k = 0; k < 40; k++) begin
      if (k == store_at) begin
        dmem_wr = 1'b1; dmem_wr_addr = saddr; dmem_wr_data = sdata;
        wr_q.push_back({saddr, sdata});
      end
      @(negedge clk);
      chk1("fill_no_wr_ack", wr_ack, 1'b0);
      if (k == 0) begin
        chk1("accept_no_mem", mem_enable, 1'b0);
        chk1("accept_ibusy", ifill_busy, 1'b0);
        chk1("accept_dbusy", dfill_busy, 1'b0);
      end else begin
        chk1("ifill_busy", ifill_busy, !own);
        chk1("dfill_busy", dfill_busy, own);
      end
      tag = own ? dcache_tag_we : icache_tag_we;
      step();
      if (tag) begin
        n = k;
        if (own) dcache_miss = 1'b0;
        else icache_miss = 1'b0;
        break;
      end
    end
    if (n < 0) fail_now("tag_timeout", 16'(own));
  endtask

  task automatic idle_store(input string name, input logic [15:0] a, input logic [15:0] d);
    dmem_wr = 1'b1; dmem_wr_addr = a; dmem_wr_data = d;
    wr_q.push_back({a, d});
    @(negedge clk);
    chk1({name, "_wr_ack"}, wr_ack, 1'b1);
    chk1({name, "_busy"}, ifill_busy || dfill_busy, 1'b0);
    step();
    dmem_wr = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    vec_t v;
    int   n, start;

    // Stores in IDLE and stray read data in IDLE.
    v = '0; v.wr = 1; v.waddr = 16'h00A4; v.wdata = 16'hBEEF;
    v.e_en = 1; v.e_wr = 1; v.e_addr = 16'h00A4; v.e_dout = 16'hBEEF; v.e_ack = 1;
    vt.push_back(v);
    v = '0; vt.push_back(v);
    v = '0; v.wr = 1; v.waddr = 16'hFFFE; v.wdata = 16'h0001;
    v.e_en = 1; v.e_wr = 1; v.e_addr = 16'hFFFE; v.e_dout = 16'h0001; v.e_ack = 1;
    vt.push_back(v);
    v = '0; v.mv = 1; vt.push_back(v);
    v = '0; v.wr = 1; v.waddr = 16'h0000; v.wdata = 16'hFFFF;
    v.e_en = 1; v.e_wr = 1; v.e_addr = 16'h0000; v.e_dout = 16'hFFFF; v.e_ack = 1;
    vt.push_back(v);
    // Cycle-exact I fill of 0x1236, latency 4: accept at 0, reads 1..8,
    // fill_we 5..12, tag_we 12, busy 1..12, IDLE at 13.
    for (int k = 0; k <= 13; k++) begin
      v = '0;
      v.imiss = (k <= 12); v.iaddr = 16'h1236;
      v.sb = (k == 0) ? 2'd1 : 2'd0;
      v.e_en = (k >= 1 && k <= 8);
      v.e_addr = 16'h1230 + 16'(2 * (k - 1));
      v.e_ifwe = (k >= 5 && k <= 12);
      v.e_itag = (k == 12);
      v.e_ibusy = (k >= 1 && k <= 12);
      vt.push_back(v);
    end

    rst = 1'b1;
    icache_miss = 0; dcache_miss = 0; dmem_wr = 0;
    icache_addr = 0; dcache_addr = 0; dmem_wr_addr = 0; dmem_wr_data = 0;
    mem_data_valid = 0; mem_data_in = 0;
    do_reset();

    foreach (vt[i]) apply_vec(vt[i]);

    // Both misses after reset: I first, then D in the first IDLE cycle.
    do_reset();
    icache_miss = 1; icache_addr = 16'h0040;
    dcache_miss = 1; dcache_addr = 16'h8000;
    push_block(1'b0, 16'h0040);
    push_block(1'b1, 16'h8000);
    wait_tag(1'b0, -1, 16'h0, 16'h0, n);
    chk("both_i_len", 16'(n), 16'd12);
    wait_tag(1'b1, -1, 16'h0, 16'h0, n);
    chk("both_d_len", 16'(n), 16'd12);

    // Round-robin after a D fill: a store goes first, then I wins the tie.
    icache_miss = 1; icache_addr = 16'h3000;
    dcache_miss = 1; dcache_addr = 16'h4000;
    push_block(1'b0, 16'h3000);
    push_block(1'b1, 16'h4000);
    idle_store("rr_store1", 16'h0100, 16'h1111);
    wait_tag(1'b0, -1, 16'h0, 16'h0, n);
    chk("rr_i_len", 16'(n), 16'd12);
    // After the I fill, a store holds the IDLE cycle, then both miss -> D.
    idle_store("rr_store2", 16'h0200, 16'h2222);
    icache_miss = 1; icache_addr = 16'h5000;
    push_block(1'b0, 16'h5000);
    wait_tag(1'b1, -1, 16'h0, 16'h0, n);
    chk("rr_d_len", 16'(n), 16'd12);

    // Store raised in the 3rd FILL cycle waits; it beats the pending D miss.
    dcache_miss = 1; dcache_addr = 16'h6000;
    push_block(1'b1, 16'h6000);
    wait_tag(1'b0, 3, 16'h0300, 16'h3333, n);
    chk("sdf_i_len", 16'(n), 16'd12);
    @(negedge clk);
    chk1("sdf_wr_ack", wr_ack, 1'b1);
    chk("sdf_addr", mem_addr, 16'h0300);
    chk1("sdf_dbusy", dfill_busy, 1'b0);
    step();
    dmem_wr = 1'b0;
    wait_tag(1'b1, -1, 16'h0, 16'h0, n);
    chk("sdf_d_len", 16'(n), 16'd12);

    // Reset after 3 words of a fill, then a fresh fill of 0x2000.
    icache_miss = 1; icache_addr = 16'h7000;
    push_block(1'b0, 16'h7000);
    start = fill_cnt;
    for (int k = 0; k < 40 && (fill_cnt - start) < 3; k++) begin
      @(negedge clk);
      step();
    end
    chk("rst_words_before", 16'(fill_cnt - start), 16'd3);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    icache_miss = 1'b0;
    flush();
    step();
    step();
    rst = 1'b0;
    icache_miss = 1; icache_addr = 16'h2000;
    push_block(1'b0, 16'h2000);
    wait_tag(1'b0, -1, 16'h0, 16'h0, n);
    chk("post_rst_len", 16'(n), 16'd12);

    repeat (LAT + 2) begin
      @(negedge clk);
      step();
    end
    chk("left_fills", 16'(exp_q.size()), 16'd0);
    chk("left_reads", 16'(rd_q.size()), 16'd0);
    chk("left_writes", 16'(wr_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
